// File: rtl/fpdiv_sequencer.sv
// Sequencer around an iterative single-precision divider core: classifies operands,
// bypasses special cases, runs the core under a cycle budget and holds the result for downstream.
module fpdiv_sequencer #(
   parameter int TIMEOUT = 32
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_A,
   input  logic [31:0] IN_B,
   output logic [31:0] DIV_A,
   output logic [31:0] DIV_B,
   output logic        DIV_RESET,
   input  logic        DIV_DONE,
   input  logic [31:0] DIV_RESULT,
   input  logic [1:0]  DIV_EXC,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_RESULT,
   output logic [2:0]  OUT_EXC,
   output logic        BUSY
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
   localparam logic [7:0]  LAST      = 8'(TIMEOUT - 1);
   localparam logic [2:0]  EXC_NONE  = 3'b000;
   localparam logic [2:0]  EXC_UNDER = 3'b001;
   localparam logic [2:0]  EXC_OVER  = 3'b010;
   localparam logic [2:0]  EXC_INV   = 3'b011;
   localparam logic [2:0]  EXC_DBZ   = 3'b100;
   localparam logic [2:0]  EXC_TMO   = 3'b101;

   state_t      state, state_next;
   logic [31:0] a_reg, b_reg;
   logic [7:0]  count;
   logic [31:0] result_next;
   logic [2:0]  exc_next;
   logic        result_load;
   logic        accept;
   logic        a_zero, b_zero, any_special, in_sign, run_sign;

   assign accept      = IN_VALID && (state == IDLE);
   assign a_zero      = (IN_A[30:0] == 31'd0);
   assign b_zero      = (IN_B[30:0] == 31'd0);
   assign any_special = (IN_A[30:23] == 8'hFF) || (IN_B[30:23] == 8'hFF);
   assign in_sign     = IN_A[31] ^ IN_B[31];
   assign run_sign    = a_reg[31] ^ b_reg[31];

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // Bypass classes resolve straight into HOLD; only normal pairs touch the divider.
   always_comb begin
      state_next  = state;
      result_next = 32'd0;
      exc_next    = EXC_NONE;
      result_load = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               result_load = 1'b1;
               state_next  = HOLD;
               if (any_special || (a_zero && b_zero)) begin
                  result_next = QNAN;
                  exc_next    = EXC_INV;
               end else if (b_zero) begin
                  result_next = {in_sign, INF_MAG};
                  exc_next    = EXC_DBZ;
               end else if (a_zero) begin
                  result_next = {in_sign, 31'd0};
               end else begin
                  result_load = 1'b0;
                  state_next  = CLEAR;
               end
            end
         end
         CLEAR: state_next = RUN;
         RUN: begin
            if (DIV_DONE) begin
               result_load = 1'b1;
               result_next = DIV_RESULT;
               state_next  = HOLD;
            end else if (count == LAST) begin
               result_load = 1'b1;
               state_next  = HOLD;
               case (DIV_EXC)
                  2'b10: begin
                     result_next = {run_sign, INF_MAG};
                     exc_next    = EXC_OVER;
                  end
                  2'b01: begin
                     result_next = {run_sign, 31'd0};
                     exc_next    = EXC_UNDER;
                  end
                  default: begin
                     result_next = QNAN;
                     exc_next    = EXC_TMO;
                  end
               endcase
            end
         end
         HOLD: if (OUT_READY) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operands are captured on every accept; the result registers only change when entering HOLD.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         a_reg      <= 32'd0;
         b_reg      <= 32'd0;
         count      <= 8'd0;
         OUT_RESULT <= 32'd0;
         OUT_EXC    <= EXC_NONE;
      end else begin
         if (accept) begin
            a_reg <= IN_A;
            b_reg <= IN_B;
         end
         if (state == RUN) count <= count + 8'd1;
         else              count <= 8'd0;
         if (result_load) begin
            OUT_RESULT <= result_next;
            OUT_EXC    <= exc_next;
         end
      end
   end

   always_comb begin
      IN_READY  = (state == IDLE);
      BUSY      = (state != IDLE);
      OUT_VALID = (state == HOLD);
      DIV_RESET = RESET || (state == CLEAR);
      DIV_A     = 32'd0;
      DIV_B     = 32'd0;
      if (state == CLEAR || state == RUN) begin
         DIV_A = a_reg;
         DIV_B = b_reg;
      end
   end

endmodule

// File: tb/tb_fpdiv_sequencer.sv
// Directed self-checking bench for fpdiv_sequencer: bypass classes, divider handshake,
// timeout selection, done/timeout tie, backpressure and mid-run reset.
module tb_fpdiv_sequencer;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] IN_A, IN_B;
   logic [31:0] DIV_A, DIV_B;
   logic        DIV_RESET;
   logic        DIV_DONE;
   logic [31:0] DIV_RESULT;
   logic [1:0]  DIV_EXC;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_RESULT;
   logic [2:0]  OUT_EXC;
   logic        BUSY;

   int total = 0;
   int bad   = 0;
   int lat;

   always #5 CLOCK = ~CLOCK;

   fpdiv_sequencer #(.TIMEOUT(32)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
      .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_RESET(DIV_RESET),
      .DIV_DONE(DIV_DONE), .DIV_RESULT(DIV_RESULT), .DIV_EXC(DIV_EXC),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
      .OUT_EXC(OUT_EXC), .BUSY(BUSY)
   );

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Offers one pair for a single edge, then scrambles the operand bus.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      IN_A     = a;
      IN_B     = b;
      IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      IN_A     = 32'hFFFF_FFFF;
      IN_B     = 32'h1234_5678;
   endtask

   task automatic waitValid(input int limit, output int cycles);
      cycles = 0;
      while (OUT_VALID !== 1'b1 && cycles < limit) begin
         tick();
         cycles++;
      end
   endtask

   task automatic drain;
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      RESET = 1'b1; IN_VALID = 1'b0; IN_A = 32'd0; IN_B = 32'd0;
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0; DIV_EXC = 2'b00; OUT_READY = 1'b0;
      tick();
      tick();
      checkOutput("rst_out_valid", OUT_VALID, 0);
      checkOutput("rst_out_result", OUT_RESULT, 0);
      checkOutput("rst_out_exc", OUT_EXC, 0);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_div_reset", DIV_RESET, 1);
      checkOutput("rst_div_a", DIV_A, 0);
      checkOutput("rst_div_b", DIV_B, 0);

      @(negedge CLOCK);
      RESET = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", IN_READY, 1);
      checkOutput("post_rst_div_reset", DIV_RESET, 0);

      // Normal divide 6.0 / 2.0 finished by the core at RUN cycle 4
      applyStimulus(32'h40C0_0000, 32'h4000_0000);
      checkOutput("clr_div_reset", DIV_RESET, 1);
      checkOutput("clr_div_a", DIV_A, 32'h40C0_0000);
      checkOutput("clr_div_b", DIV_B, 32'h4000_0000);
      checkOutput("clr_in_ready", IN_READY, 0);
      checkOutput("clr_busy", BUSY, 1);
      DIV_DONE = 1'b1; DIV_RESULT = 32'hDEAD_BEEF;
      tick();
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0;
      checkOutput("run0_div_reset", DIV_RESET, 0);
      checkOutput("run0_out_valid", OUT_VALID, 0);
      checkOutput("run0_div_a", DIV_A, 32'h40C0_0000);
      repeat (4) tick();
      checkOutput("run4_out_valid", OUT_VALID, 0);
      checkOutput("run4_div_b", DIV_B, 32'h4000_0000);
      DIV_DONE = 1'b1; DIV_RESULT = 32'h4040_0000;
      tick();
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0;
      checkOutput("norm_out_valid", OUT_VALID, 1);
      checkOutput("norm_result", OUT_RESULT, 32'h4040_0000);
      checkOutput("norm_exc", OUT_EXC, 0);
      checkOutput("hold_div_a", DIV_A, 0);

      // Backpressure: flags packed as {OUT_VALID, IN_READY, OUT_EXC}
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_result", OUT_RESULT, 32'h4040_0000);
         checkOutput("bp_flags", {OUT_VALID, IN_READY, OUT_EXC}, 32'h10);
      end

      // Drain while a new pair is already offered: it must wait a cycle
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_A = 32'hBF80_0000; IN_B = 32'h0000_0000;
      tick();
      OUT_READY = 1'b0;
      checkOutput("drain_out_valid", OUT_VALID, 0);
      checkOutput("drain_in_ready", IN_READY, 1);
      checkOutput("drain_busy", BUSY, 0);
      tick();
      IN_VALID = 1'b0;
      checkOutput("dbz_out_valid", OUT_VALID, 1);
      checkOutput("dbz_result", OUT_RESULT, 32'hFF80_0000);
      checkOutput("dbz_exc", OUT_EXC, 3'b100);
      checkOutput("dbz_div_reset", DIV_RESET, 0);
      drain();

      applyStimulus(32'h7FC0_0000, 32'h3F80_0000);
      checkOutput("nan_result", OUT_RESULT, 32'h7FC0_0000);
      checkOutput("nan_exc", OUT_EXC, 3'b011);
      drain();
      applyStimulus(32'h0000_0000, 32'h0000_0000);
      checkOutput("zz_result", OUT_RESULT, 32'h7FC0_0000);
      checkOutput("zz_exc", OUT_EXC, 3'b011);
      drain();
      applyStimulus(32'h8000_0000, 32'h3F80_0000);
      checkOutput("az_valid", OUT_VALID, 1);
      checkOutput("az_result", OUT_RESULT, 32'h8000_0000);
      checkOutput("az_exc", OUT_EXC, 3'b000);
      drain();

      // Timeouts with the three DIV_EXC selections
      DIV_EXC = 2'b10;
      applyStimulus(32'hC000_0000, 32'h0080_0001);
      waitValid(100, lat);
      checkOutput("ovf_latency", lat, 33);
      checkOutput("ovf_result", OUT_RESULT, 32'hFF80_0000);
      checkOutput("ovf_exc", OUT_EXC, 3'b010);
      drain();
      DIV_EXC = 2'b01;
      applyStimulus(32'h0080_0000, 32'h7F00_0000);
      waitValid(100, lat);
      checkOutput("unf_latency", lat, 33);
      checkOutput("unf_result", OUT_RESULT, 32'h0000_0000);
      checkOutput("unf_exc", OUT_EXC, 3'b001);
      drain();
      DIV_EXC = 2'b11;
      applyStimulus(32'h3F80_0000, 32'h4000_0000);
      waitValid(100, lat);
      checkOutput("tmo_latency", lat, 33);
      checkOutput("tmo_result", OUT_RESULT, 32'h7FC0_0000);
      checkOutput("tmo_exc", OUT_EXC, 3'b101);
      drain();

      // Done arriving on the last budgeted RUN cycle beats the timeout
      DIV_EXC = 2'b10;
      applyStimulus(32'h40C0_0000, 32'h4000_0000);
      repeat (32) tick();
      checkOutput("tie_pre_valid", OUT_VALID, 0);
      DIV_DONE = 1'b1; DIV_RESULT = 32'h3F80_0000;
      tick();
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0; DIV_EXC = 2'b00;
      checkOutput("tie_valid", OUT_VALID, 1);
      checkOutput("tie_result", OUT_RESULT, 32'h3F80_0000);
      checkOutput("tie_exc", OUT_EXC, 3'b000);
      drain();

      // Reset at RUN cycle 3 aborts the operation
      applyStimulus(32'h40C0_0000, 32'h4000_0000);
      repeat (4) tick();
      checkOutput("mid_busy", BUSY, 1);
      RESET = 1'b1;
      #1;
      checkOutput("mid_rst_div_reset", DIV_RESET, 1);
      checkOutput("mid_rst_busy", BUSY, 0);
      checkOutput("mid_rst_out_valid", OUT_VALID, 0);
      checkOutput("mid_rst_div_a", DIV_A, 0);
      checkOutput("mid_rst_result", OUT_RESULT, 0);
      tick();
      @(negedge CLOCK);
      RESET = 1'b0;
      DIV_DONE = 1'b1; DIV_RESULT = 32'hDEAD_BEEF;
      repeat (3) tick();
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0;
      checkOutput("after_rst_out_valid", OUT_VALID, 0);
      checkOutput("after_rst_busy", BUSY, 0);

      applyStimulus(32'h3F80_0000, 32'h3F80_0000);
      tick();
      DIV_DONE = 1'b1; DIV_RESULT = 32'h3F80_0000;
      tick();
      DIV_DONE = 1'b0; DIV_RESULT = 32'd0;
      checkOutput("resume_valid", OUT_VALID, 1);
      checkOutput("resume_result", OUT_RESULT, 32'h3F80_0000);
      checkOutput("resume_exc", OUT_EXC, 3'b000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
